// File: rtl/gcd_pkg.sv
// Shared GCD job definitions: FSM state encoding, default widths, round-robin pick rule.
// Imported by the arbiter/controller, its round-robin sub-block and the datapath.
package gcd_pkg;

    localparam int GCD_W        = 16;
    localparam int GCD_MAX_ITER = 65535;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOADA = 3'd1,
        LOADB = 3'd2,
        ITER  = 3'd3,
        RESP  = 3'd4
    } gcd_state_e;

    // Winning requester id; ptr holds the last-granted id, so a tie goes to the other one.
    function automatic logic rr_pick(input logic [1:0] req, input logic ptr);
        logic win;
        win = req[1];
        if (req[0] && req[1]) begin
            win = ~ptr;
        end
        return win;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, pointer updated when en is high.
// Zero latency; no backpressure of its own, the caller decides when a grant is taken.
module rr_arb2
    import gcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic ptr_q;
    logic win;

    assign win = rr_pick(req, ptr_q);

    always_comb begin
        gnt = 2'b00;
        if (|req) begin
            gnt = win ? 2'b10 : 2'b01;
        end
    end

    // Pointer starts at 1 so requester 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= 1'b1;
        end else if (en && (|req)) begin
            ptr_q <= win;
        end
    end

endmodule

// File: rtl/gcd_arbiter.sv
// Two-requester GCD job controller driving an external subtractive datapath.
// Grant at T, result strobe at T+4+N (T+1 for a zero operand); one job in flight, others wait.
module gcd_arbiter
    import gcd_pkg::*;
#(
    parameter int W        = GCD_W,
    parameter int MAX_ITER = GCD_MAX_ITER
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0,
    input  logic         req1,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         rsp_valid,
    output logic         rsp_id,
    output logic [W-1:0] rsp_gcd,
    output logic         rsp_err,
    output logic [W-1:0] dp_data_in,
    output logic         ldA,
    output logic         ldB,
    output logic         sel1,
    output logic         sel2,
    output logic         sel_in,
    input  logic         lt,
    input  logic         gt,
    input  logic         eq,
    input  logic [W-1:0] dp_result
);

    localparam logic [W-1:0] MAX_W = W'(MAX_ITER);

    gcd_state_e   state_q;
    logic [W-1:0] b_q;
    logic         id_q;
    logic [W-1:0] cnt_q;

    logic         ldA_q;
    logic         ldB_q;
    logic         sel_in_q;
    logic [W-1:0] din_q;
    logic         rsp_valid_q;
    logic         rsp_id_q;
    logic [W-1:0] rsp_gcd_q;
    logic         rsp_err_q;

    logic [1:0]   rr_gnt;
    logic         arb_en;
    logic         sel_id;
    logic [W-1:0] sel_a;
    logic [W-1:0] sel_b;

    logic         it_sub_a;
    logic         it_sub_b;
    logic         it_done;
    logic         it_tmo;

    // A grant is only taken in IDLE, and never on a cycle that is being reset.
    assign arb_en = (state_q == IDLE) && rst_n && (req0 || req1);

    rr_arb2 u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({req1, req0}),
        .en    (arb_en),
        .gnt   (rr_gnt)
    );

    assign gnt0   = arb_en & rr_gnt[0];
    assign gnt1   = arb_en & rr_gnt[1];
    assign sel_id = rr_gnt[1];
    assign sel_a  = sel_id ? a1 : a0;
    assign sel_b  = sel_id ? b1 : b0;

    always_comb begin
        it_sub_a = 1'b0;
        it_sub_b = 1'b0;
        it_done  = 1'b0;
        it_tmo   = 1'b0;
        if (state_q == ITER) begin
            if (eq) begin
                it_done = 1'b1;
            end else if (cnt_q == MAX_W) begin
                it_tmo = 1'b1;
            end else if (lt) begin
                it_sub_b = 1'b1;
            end else if (gt) begin
                it_sub_a = 1'b1;
            end
        end
    end

    // Load controls are registered; subtract controls follow the live compare flags.
    assign ldA        = ldA_q | it_sub_a;
    assign ldB        = ldB_q | it_sub_b;
    assign sel1       = it_sub_b;
    assign sel2       = it_sub_a;
    assign sel_in     = sel_in_q;
    assign dp_data_in = din_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_gcd    = rsp_gcd_q;
    assign rsp_err    = rsp_err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            b_q         <= '0;
            id_q        <= 1'b0;
            cnt_q       <= '0;
            ldA_q       <= 1'b0;
            ldB_q       <= 1'b0;
            sel_in_q    <= 1'b0;
            din_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_gcd_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            ldA_q       <= 1'b0;
            ldB_q       <= 1'b0;
            sel_in_q    <= 1'b0;
            din_q       <= '0;
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (arb_en) begin
                        id_q  <= sel_id;
                        b_q   <= sel_b;
                        cnt_q <= '0;
                        if ((sel_a == '0) || (sel_b == '0)) begin
                            // gcd(x,0) = x; both zero has no defined result.
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_id_q    <= sel_id;
                            rsp_gcd_q   <= sel_a | sel_b;
                            rsp_err_q   <= (sel_a == '0) && (sel_b == '0);
                        end else begin
                            state_q  <= LOADA;
                            ldA_q    <= 1'b1;
                            sel_in_q <= 1'b1;
                            din_q    <= sel_a;
                        end
                    end
                end
                LOADA: begin
                    state_q  <= LOADB;
                    ldB_q    <= 1'b1;
                    sel_in_q <= 1'b1;
                    din_q    <= b_q;
                end
                LOADB: begin
                    state_q <= ITER;
                end
                ITER: begin
                    if (it_done || it_tmo) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= id_q;
                        rsp_gcd_q   <= it_done ? dp_result : '0;
                        rsp_err_q   <= it_tmo;
                    end else if (it_sub_a || it_sub_b) begin
                        cnt_q <= cnt_q + W'(1);
                    end
                end
                RESP: begin
                    state_q   <= IDLE;
                    rsp_id_q  <= 1'b0;
                    rsp_gcd_q <= '0;
                    rsp_err_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_arbiter.sv
// Bench for gcd_arbiter: two instances (default and MAX_ITER=4), each with a behavioural datapath.
// Expected gcd/err/latency come from Euclid's algorithm (quotient sums give the subtract count).
module tb_gcd_arbiter;

    localparam int W   = 16;
    localparam int DEF = 65535;
    localparam int TMO = 4;

    logic         clk;
    logic         rst_n;
    logic         req0 [2];
    logic         req1 [2];
    logic [W-1:0] a0 [2];
    logic [W-1:0] b0 [2];
    logic [W-1:0] a1 [2];
    logic [W-1:0] b1 [2];
    logic         gnt0 [2];
    logic         gnt1 [2];
    logic         rsp_valid [2];
    logic         rsp_id [2];
    logic [W-1:0] rsp_gcd [2];
    logic         rsp_err [2];
    logic [W-1:0] din [2];
    logic         ldA [2];
    logic         ldB [2];
    logic         sel1 [2];
    logic         sel2 [2];
    logic         sel_in [2];
    logic         lt [2];
    logic         gt [2];
    logic         eq [2];
    logic [W-1:0] dpa [2];
    logic [W-1:0] dpb [2];

    int checks = 0;
    int errors = 0;
    int ptr    = 1;

    gcd_arbiter #(.W(W)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0[0]), .req1(req1[0]), .a0(a0[0]), .b0(b0[0]), .a1(a1[0]), .b1(b1[0]),
        .gnt0(gnt0[0]), .gnt1(gnt1[0]), .rsp_valid(rsp_valid[0]), .rsp_id(rsp_id[0]),
        .rsp_gcd(rsp_gcd[0]), .rsp_err(rsp_err[0]), .dp_data_in(din[0]),
        .ldA(ldA[0]), .ldB(ldB[0]), .sel1(sel1[0]), .sel2(sel2[0]), .sel_in(sel_in[0]),
        .lt(lt[0]), .gt(gt[0]), .eq(eq[0]), .dp_result(dpa[0])
    );

    gcd_arbiter #(.W(W), .MAX_ITER(TMO)) u_tmo (
        .clk(clk), .rst_n(rst_n),
        .req0(req0[1]), .req1(req1[1]), .a0(a0[1]), .b0(b0[1]), .a1(a1[1]), .b1(b1[1]),
        .gnt0(gnt0[1]), .gnt1(gnt1[1]), .rsp_valid(rsp_valid[1]), .rsp_id(rsp_id[1]),
        .rsp_gcd(rsp_gcd[1]), .rsp_err(rsp_err[1]), .dp_data_in(din[1]),
        .ldA(ldA[1]), .ldB(ldB[1]), .sel1(sel1[1]), .sel2(sel2[1]), .sel_in(sel_in[1]),
        .lt(lt[1]), .gt(gt[1]), .eq(eq[1]), .dp_result(dpa[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath: A and B registers behind an input / B-A / A-B mux.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [W-1:0] mux;
            if (sel_in[k])                 mux = din[k];
            else if (sel1[k] && !sel2[k])  mux = dpb[k] - dpa[k];
            else if (!sel1[k] && sel2[k])  mux = dpa[k] - dpb[k];
            else                           mux = '0;
            if (ldA[k]) dpa[k] <= mux;
            if (ldB[k]) dpb[k] <= mux;
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            lt[k] = dpa[k] < dpb[k];
            gt[k] = dpa[k] > dpb[k];
            eq[k] = dpa[k] == dpb[k];
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outs(input int k);
        return {22'd0, gnt0[k], gnt1[k], rsp_valid[k], rsp_id[k], rsp_err[k],
                ldA[k], ldB[k], sel1[k], sel2[k], sel_in[k], rsp_gcd[k], din[k]};
    endfunction

    // Reference: Euclid; subtract count = sum of quotients - 1.
    function automatic void model(input int a, input int b, input int mx,
                                  output int g, output bit err, output int lat);
        int x, y, r, n;
        if (a == 0 || b == 0) begin
            g = a | b; err = (a == 0 && b == 0); lat = 1;
            return;
        end
        x = a; y = b; n = 0;
        while (y != 0) begin
            n += x / y; r = x % y; x = y; y = r;
        end
        n -= 1;
        if (n > mx) begin g = 0; err = 1'b1; lat = 4 + mx; end
        else        begin g = x; err = 1'b0; lat = 4 + n;  end
    endfunction

    task automatic wait_grant(input int k, input int exp_id, output bit found);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (gnt0[k] || gnt1[k]) found = 1'b1;
            else @(posedge clk);
        end
        chk("grant_seen", 64'(found), 64'd1);
        if (found) chk("grant_id", {62'd0, gnt1[k], gnt0[k]}, (exp_id != 0) ? 64'd2 : 64'd1);
    endtask

    // Call after driving inputs at posedge+1; returns at posedge+1 of the cycle after RESP.
    task automatic run_job(input int k, input int exp_id, input int a, input int b, input int mx);
        int g, lat;
        bit err, found;
        model(a, b, mx, g, err, lat);
        wait_grant(k, exp_id, found);
        if (!found) return;
        ptr = exp_id;
        @(posedge clk); #1;
        if (exp_id == 0) begin req0[k] = 1'b0; a0[k] = W'($urandom); b0[k] = W'($urandom); end
        else             begin req1[k] = 1'b0; a1[k] = W'($urandom); b1[k] = W'($urandom); end
        for (int t = 1; t <= lat; t++) begin
            @(negedge clk);
            chk("rsp_valid_timing", 64'(rsp_valid[k]), 64'(t == lat));
            chk("no_grant_in_flight", 64'(gnt0[k] | gnt1[k]), 64'd0);
            if (t == 1 && lat > 1)
                chk("loada_ctrl", {45'd0, ldA[k], ldB[k], sel_in[k], din[k]}, {45'd0, 3'b101, W'(a)});
            if (t == 2 && lat > 1)
                chk("loadb_ctrl", {45'd0, ldA[k], ldB[k], sel_in[k], din[k]}, {45'd0, 3'b011, W'(b)});
            if (t == lat) begin
                chk("rsp_id", 64'(rsp_id[k]), 64'(exp_id));
                chk("rsp_gcd", 64'(rsp_gcd[k]), 64'(g));
                chk("rsp_err", 64'(rsp_err[k]), 64'(err));
            end
            if (t < lat) @(posedge clk);
        end
        @(posedge clk); #1;
        chk("rsp_one_cycle", 64'(rsp_valid[k]), 64'd0);
    endtask

    initial begin
        bit found;
        int ra0, rb0, ra1, rb1, mode, first;
        for (int k = 0; k < 2; k++) begin
            req0[k] = 0; req1[k] = 0; a0[k] = '0; b0[k] = '0; a1[k] = '0; b1[k] = '0;
            dpa[k] = '0; dpb[k] = '0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs_dut", outs(0), 64'd0);
        chk("reset_outs_tmo", outs(1), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Contention after reset: requester 0 first, then 1.
        req0[0] = 1; a0[0] = 16'd9;  b0[0] = 16'd6;
        req1[0] = 1; a1[0] = 16'd35; b1[0] = 16'd14;
        run_job(0, 0, 9, 6, DEF);
        run_job(0, 1, 35, 14, DEF);

        // Third pair: pointer is 1, so requester 0 wins; requester 1 has a zero operand.
        req0[0] = 1; a0[0] = 16'd12; b0[0] = 16'd8;
        req1[0] = 1; a1[0] = 16'd0;  b1[0] = 16'd21;
        run_job(0, 0, 12, 8, DEF);
        run_job(0, 1, 0, 21, DEF);

        req0[0] = 1; a0[0] = 16'd0; b0[0] = 16'd0;
        run_job(0, 0, 0, 0, DEF);
        req0[0] = 1; a0[0] = 16'd12; b0[0] = 16'd8;
        run_job(0, 0, 12, 8, DEF);
        req1[0] = 1; a1[0] = 16'd7; b1[0] = 16'd7;
        run_job(0, 1, 7, 7, DEF);

        // Timeout instance.
        req0[1] = 1; a0[1] = 16'd100; b0[1] = 16'd1;
        run_job(1, 0, 100, 1, TMO);
        req1[1] = 1; a1[1] = 16'd10; b1[1] = 16'd2;
        run_job(1, 1, 10, 2, TMO);

        // Reset in the middle of a long job.
        req0[0] = 1; a0[0] = 16'hFFFF; b0[0] = 16'd1;
        wait_grant(0, 0, found);
        @(posedge clk); #1;
        req0[0] = 0;
        repeat (8) @(posedge clk);
        #1;
        chk("iter_active_before_reset", 64'(ldA[0]), 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("outs_after_midjob_reset", outs(0), 64'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("no_rsp_after_abort", 64'(rsp_valid[0]), 64'd0);
        end
        ptr = 1;
        @(posedge clk); #1;
        req1[0] = 1; a1[0] = 16'd18; b1[0] = 16'd12;
        run_job(0, 1, 18, 12, DEF);

        // Randomised jobs with a round-robin pointer model.
        for (int n = 0; n < 16; n++) begin
            mode = $urandom_range(0, 2);
            ra0 = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 200);
            rb0 = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 200);
            ra1 = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 200);
            rb1 = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 200);
            a0[0] = W'(ra0); b0[0] = W'(rb0); a1[0] = W'(ra1); b1[0] = W'(rb1);
            if (mode == 0) begin
                req0[0] = 1; run_job(0, 0, ra0, rb0, DEF);
            end else if (mode == 1) begin
                req1[0] = 1; run_job(0, 1, ra1, rb1, DEF);
            end else begin
                req0[0] = 1; req1[0] = 1;
                first = 1 - ptr;
                if (first == 0) begin
                    run_job(0, 0, ra0, rb0, DEF);
                    run_job(0, 1, ra1, rb1, DEF);
                end else begin
                    run_job(0, 1, ra1, rb1, DEF);
                    run_job(0, 0, ra0, rb0, DEF);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
